// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared types and helpers for the single-clock FIFO controller and its RAM.
package sync_fifo_ctrl_pkg;

  typedef enum logic {
    RD_STD  = 1'b0,
    RD_FWFT = 1'b1
  } rd_mode_e;

  // Pointers and the fill count carry one extra bit so full and empty stay distinct.
  function automatic int ptr_width(input int addr_len);
    return addr_len + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_sdp_ram.sv
// Simple dual-port RAM, one clock, registered read data (1-cycle read latency), no array reset.
module fifo_sdp_ram
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_LEN   = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_LEN-1:0]   i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_LEN-1:0]   i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_LEN];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock block-RAM FIFO with standard or fall-through read, fill count,
// almost-empty/full thresholds, synchronous flush and sticky error flags.
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_LEN         = 10,
  parameter int DATA_WIDTH       = 32,
  parameter int FWFT             = 0,
  parameter int ALM_EMPTY_THRESH = 2,
  parameter int ALM_FULL_THRESH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  ENQ,
  output logic                  FULL,
  output logic                  ALM_FULL,
  output logic [DATA_WIDTH-1:0] Q,
  input  logic                  DEQ,
  output logic                  EMPTY,
  output logic                  ALM_EMPTY,
  output logic [ADDR_LEN:0]     COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  input  logic                  CLR_ERR
);

  localparam int PW       = ptr_width(ADDR_LEN);
  localparam int MEM_SIZE = 2**ADDR_LEN;
  localparam rd_mode_e MODE = (FWFT != 0) ? RD_FWFT : RD_STD;
  localparam logic [PW-1:0] C_SIZE = PW'(MEM_SIZE);
  localparam logic [PW-1:0] C_AE   = PW'(ALM_EMPTY_THRESH);
  localparam logic [PW-1:0] C_AF   = PW'(MEM_SIZE - ALM_FULL_THRESH);

  if (ALM_EMPTY_THRESH >= MEM_SIZE || ALM_FULL_THRESH >= MEM_SIZE) begin : g_bad_thresh
    $error("sync_fifo_ctrl: almost-empty/full thresholds must be below the FIFO depth");
  end

  logic [PW-1:0]         r_wptr, r_rptr, r_count;
  logic                  r_empty, r_full, r_alm_empty, r_alm_full;
  logic                  r_ovf, r_unf, r_q_loaded;
  logic                  w_wr, w_rd, w_ram_rd, w_empty_next;
  logic [PW-1:0]         w_count_next;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Accept rules: a write happens iff ENQ && !FULL, a pop iff DEQ && !EMPTY,
  // both judged on the flags registered at the start of the cycle; FLUSH overrides both.
  assign w_wr = ENQ && !r_full  && !FLUSH;
  assign w_rd = DEQ && !r_empty && !FLUSH;

  assign w_count_next = FLUSH ? '0
                      : r_count + {{(PW-1){1'b0}}, w_wr} - {{(PW-1){1'b0}}, w_rd};

  if (MODE == RD_FWFT) begin : g_fwft
    // Output stage is valid exactly when EMPTY is low; refill it whenever it is
    // (or is about to be) vacant and the RAM holds a word written on an earlier edge.
    logic w_mem_ne;
    assign w_mem_ne     = (r_wptr != r_rptr);
    assign w_ram_rd     = (r_empty || w_rd) && w_mem_ne && !FLUSH;
    assign w_empty_next = FLUSH ? 1'b1 : !(w_ram_rd || (!r_empty && !w_rd));
  end else begin : g_std
    assign w_ram_rd     = w_rd;
    assign w_empty_next = (w_count_next == '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_alm_empty <= 1'b1;
      r_alm_full  <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_q_loaded  <= 1'b0;
    end else begin
      // A new error in the same cycle as CLR_ERR wins.
      r_ovf <= (r_ovf && !CLR_ERR) || (ENQ && r_full);
      r_unf <= (r_unf && !CLR_ERR) || (DEQ && r_empty);
      if (FLUSH) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_wr)     r_wptr <= r_wptr + 1'b1;
        if (w_ram_rd) r_rptr <= r_rptr + 1'b1;
      end
      if (w_ram_rd) r_q_loaded <= 1'b1;
      r_count     <= w_count_next;
      r_empty     <= w_empty_next;
      r_full      <= (w_count_next == C_SIZE);
      r_alm_empty <= (w_count_next <= C_AE);
      r_alm_full  <= (w_count_next >= C_AF);
    end
  end

  fifo_sdp_ram #(
    .ADDR_LEN   (ADDR_LEN),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clk     (CLK),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wptr[ADDR_LEN-1:0]),
    .i_wr_data (D),
    .i_rd_en   (w_ram_rd),
    .i_rd_addr (r_rptr[ADDR_LEN-1:0]),
    .o_rd_data (w_rd_data)
  );

  // RAM output is unreset; mask it until the first read so Q shows zero out of reset.
  assign Q         = r_q_loaded ? w_rd_data : '0;
  assign COUNT     = r_count;
  assign EMPTY     = r_empty;
  assign FULL      = r_full;
  assign ALM_EMPTY = r_alm_empty;
  assign ALM_FULL  = r_alm_full;
  assign OVERFLOW  = r_ovf;
  assign UNDERFLOW = r_unf;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a standard-mode and a fall-through instance share stimulus
// and are compared with queue-based reference models plus directed vectors.
module tb_sync_fifo_ctrl;

  localparam int AL    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AE_T  = 2;
  localparam int AF_T  = 3;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          flush = 1'b0;
  logic          enq   = 1'b0;
  logic          deq   = 1'b0;
  logic          clr   = 1'b0;
  logic [DW-1:0] d     = '0;

  logic          s_full, s_afull, s_empty, s_aempty, s_ovf, s_unf;
  logic [DW-1:0] s_q;
  logic [AL:0]   s_cnt;
  logic          f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;
  logic [DW-1:0] f_q;
  logic [AL:0]   f_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.ADDR_LEN(AL), .DATA_WIDTH(DW), .FWFT(0),
                   .ALM_EMPTY_THRESH(AE_T), .ALM_FULL_THRESH(AF_T)) dut_std (
    .CLK(clk), .RST(rst), .FLUSH(flush), .D(d), .ENQ(enq), .FULL(s_full),
    .ALM_FULL(s_afull), .Q(s_q), .DEQ(deq), .EMPTY(s_empty), .ALM_EMPTY(s_aempty),
    .COUNT(s_cnt), .OVERFLOW(s_ovf), .UNDERFLOW(s_unf), .CLR_ERR(clr)
  );

  sync_fifo_ctrl #(.ADDR_LEN(AL), .DATA_WIDTH(DW), .FWFT(1),
                   .ALM_EMPTY_THRESH(AE_T), .ALM_FULL_THRESH(AF_T)) dut_fw (
    .CLK(clk), .RST(rst), .FLUSH(flush), .D(d), .ENQ(enq), .FULL(f_full),
    .ALM_FULL(f_afull), .Q(f_q), .DEQ(deq), .EMPTY(f_empty), .ALM_EMPTY(f_aempty),
    .COUNT(f_cnt), .OVERFLOW(f_ovf), .UNDERFLOW(f_unf), .CLR_ERR(clr)
  );

  // Reference models: std keeps all words in one queue; fwft keeps RAM words in a
  // queue plus one visible output word that is refilled from an earlier-written head.
  logic [DW-1:0] ms_q[$];
  logic [DW-1:0] ms_out;
  bit            ms_ovf, ms_unf;
  logic [DW-1:0] mf_mem[$];
  logic [DW-1:0] mf_out;
  bit            mf_ov, mf_ovf, mf_unf;
  bit            m_sfull0, m_sempty0, m_ffull0, m_fempty0, m_fne0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_q.delete(); ms_out = '0; ms_ovf = 0; ms_unf = 0;
      mf_mem.delete(); mf_out = '0; mf_ov = 0; mf_ovf = 0; mf_unf = 0;
    end else begin
      m_sfull0  = (ms_q.size() == DEPTH);
      m_sempty0 = (ms_q.size() == 0);
      m_ffull0  = (mf_mem.size() + (mf_ov ? 1 : 0) == DEPTH);
      m_fempty0 = !mf_ov;
      m_fne0    = (mf_mem.size() != 0);
      ms_ovf = (ms_ovf && !clr) || (enq && m_sfull0);
      ms_unf = (ms_unf && !clr) || (deq && m_sempty0);
      mf_ovf = (mf_ovf && !clr) || (enq && m_ffull0);
      mf_unf = (mf_unf && !clr) || (deq && m_fempty0);
      if (flush) begin
        ms_q.delete();
        mf_mem.delete();
        mf_ov = 0;
      end else begin
        if (deq && !m_sempty0) ms_out = ms_q.pop_front();
        if (enq && !m_sfull0)  ms_q.push_back(d);
        if (deq && mf_ov)      mf_ov = 0;
        if (!mf_ov && m_fne0) begin
          mf_out = mf_mem.pop_front();
          mf_ov  = 1;
        end
        if (enq && !m_ffull0) mf_mem.push_back(d);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    int sc;
    int fc;
    sc = ms_q.size();
    fc = mf_mem.size() + (mf_ov ? 1 : 0);
    chk("std count",  int'(s_cnt),    sc);
    chk("std empty",  int'(s_empty),  int'(sc == 0));
    chk("std full",   int'(s_full),   int'(sc == DEPTH));
    chk("std aempty", int'(s_aempty), int'(sc <= AE_T));
    chk("std afull",  int'(s_afull),  int'(sc >= DEPTH - AF_T));
    chk("std q",      int'(s_q),      int'(ms_out));
    chk("std ovf",    int'(s_ovf),    int'(ms_ovf));
    chk("std unf",    int'(s_unf),    int'(ms_unf));
    chk("fw count",   int'(f_cnt),    fc);
    chk("fw empty",   int'(f_empty),  int'(!mf_ov));
    chk("fw full",    int'(f_full),   int'(fc == DEPTH));
    chk("fw aempty",  int'(f_aempty), int'(fc <= AE_T));
    chk("fw afull",   int'(f_afull),  int'(fc >= DEPTH - AF_T));
    chk("fw q",       int'(f_q),      int'(mf_out));
    chk("fw ovf",     int'(f_ovf),    int'(mf_ovf));
    chk("fw unf",     int'(f_unf),    int'(mf_unf));
  endtask

  task automatic cyc(input bit e, input bit dq, input bit f, input bit c, input logic [DW-1:0] dd);
    enq = e; deq = dq; flush = f; clr = c; d = dd;
    @(posedge clk); #1;
    enq = 0; deq = 0; flush = 0; clr = 0;
    cmp_model();
  endtask

  // Raises RST between edges and checks outputs before any clock edge arrives.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst std count", int'(s_cnt), 0);    chk("rst fw count", int'(f_cnt), 0);
    chk("rst std empty", int'(s_empty), 1);  chk("rst fw empty", int'(f_empty), 1);
    chk("rst std aempty", int'(s_aempty), 1); chk("rst fw aempty", int'(f_aempty), 1);
    chk("rst std full", int'(s_full), 0);    chk("rst fw full", int'(f_full), 0);
    chk("rst std afull", int'(s_afull), 0);  chk("rst fw afull", int'(f_afull), 0);
    chk("rst std q", int'(s_q), 0);          chk("rst fw q", int'(f_q), 0);
    chk("rst std ovf", int'(s_ovf), 0);      chk("rst fw ovf", int'(f_ovf), 0);
    chk("rst std unf", int'(s_unf), 0);      chk("rst fw unf", int'(f_unf), 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit            e, dq, c;
    logic [DW-1:0] dd;
    int            s_cnt, s_emp, s_q, s_unf, f_cnt, f_emp, f_q;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1, 'h00, 1, 0, 1, 'h00};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1, 'h00, 0, 0, 1, 'h00};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 8'hA5, 1, 0, 'h00, 0, 1, 1, 'h00};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 0, 'h00, 0, 1, 0, 'hA5};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1, 'hA5, 0, 0, 1, 'hA5};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h11, 1, 0, 'hA5, 0, 1, 1, 'hA5};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h22, 2, 0, 'hA5, 0, 2, 0, 'h11};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 8'h33, 2, 0, 'h11, 0, 2, 0, 'h22};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 0, 'h22, 0, 1, 0, 'h33};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1, 'h33, 0, 0, 1, 'h33};

    #1;
    do_reset();

    // Underflow/clear, fall-through latency, simultaneous push/pop.
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].e, tbl[i].dq, 1'b0, tbl[i].c, tbl[i].dd);
      chk($sformatf("vec%0d std count", i), int'(s_cnt),   tbl[i].s_cnt);
      chk($sformatf("vec%0d std empty", i), int'(s_empty), tbl[i].s_emp);
      chk($sformatf("vec%0d std q", i),     int'(s_q),     tbl[i].s_q);
      chk($sformatf("vec%0d std unf", i),   int'(s_unf),   tbl[i].s_unf);
      chk($sformatf("vec%0d fw count", i),  int'(f_cnt),   tbl[i].f_cnt);
      chk($sformatf("vec%0d fw empty", i),  int'(f_empty), tbl[i].f_emp);
      chk($sformatf("vec%0d fw q", i),      int'(f_q),     tbl[i].f_q);
    end

    // Fill to full with threshold checks, overflow, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
      chk("fill std count", int'(s_cnt), i + 1);
      chk("fill fw count", int'(f_cnt), i + 1);
      chk("fill std full", int'(s_full), int'(i == DEPTH - 1));
      chk("fill std aempty", int'(s_aempty), int'(i + 1 <= 2));
      chk("fill std afull", int'(s_afull), int'(i + 1 >= 13));
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'hEE);
    chk("ovf std", int'(s_ovf), 1); chk("ovf fw", int'(f_ovf), 1);
    chk("ovf std count", int'(s_cnt), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("drain std q", int'(s_q), i);
    end
    chk("drained std empty", int'(s_empty), 1); chk("drained std count", int'(s_cnt), 0);
    chk("drained fw empty", int'(f_empty), 1);  chk("drained fw count", int'(f_cnt), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("clr std ovf", int'(s_ovf), 0);

    // Steady push/pop at COUNT=8 across pointer wrap.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h40 + i));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int j = 0; j < 40; j++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h48 + j));
      chk("wrap std count", int'(s_cnt), 8);
      chk("wrap fw count", int'(f_cnt), 8);
      chk("wrap std q", int'(s_q), int'(8'(8'h40 + j)));
    end
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Flush at COUNT=9 with ENQ high keeps OVERFLOW and Q.
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("pre-flush std count", int'(s_cnt), 9); chk("pre-flush fw count", int'(f_cnt), 9);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h77);
    chk("flush std count", int'(s_cnt), 0);  chk("flush fw count", int'(f_cnt), 0);
    chk("flush std empty", int'(s_empty), 1); chk("flush fw empty", int'(f_empty), 1);
    chk("flush std ovf", int'(s_ovf), 1);    chk("flush fw ovf", int'(f_ovf), 1);
    chk("flush std q", int'(s_q), 6);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

    // Randomized traffic with alternating fill/drain bias.
    for (int k = 0; k < 800; k++) begin
      int  p;
      bit  re, rd, rf, rc;
      p  = ((k / 100) % 2 == 1) ? 80 : 25;
      re = ($urandom_range(0, 99) < p);
      rd = ($urandom_range(0, 99) < 100 - p);
      rf = ($urandom_range(0, 199) == 0);
      rc = ($urandom_range(0, 49) == 0);
      cyc(re, rd, rf, rc, 8'($urandom));
    end

    // Reset mid-burst at COUNT=5, then a clean write/read.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hC0 + i));
    chk("burst std count", int'(s_cnt), 5);
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("post-rst fw q", int'(f_q), 'h5A); chk("post-rst fw empty", int'(f_empty), 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("post-rst std q", int'(s_q), 'h5A);
    chk("post-rst std empty", int'(s_empty), 1); chk("post-rst fw empty2", int'(f_empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
